packet_builder: RTL
===================

Name: packet_builder

Overview:
- Transmit-side counterpart of the UART command parser. Serialises one command frame per request into a byte stream for the UART transmitter.
- Frame format: 0xAA header, command byte, big-endian payload, 0x55 footer.
- Sits between the control/telemetry logic and the UART TX byte interface. Used to send frequency, phase and amplitude settings, or to echo them back to the host.

Parameters:
- HEADER, 8'hAA, first byte of every frame
- FOOTER, 8'h55, last byte of every frame
- CMD_FREQ, 8'h01, frequency command, 4 payload bytes
- CMD_PHASE, 8'h02, phase command, 4 payload bytes
- CMD_AMP, 8'h03, amplitude command, 2 payload bytes

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_cmd  in  8  command byte of the requested frame
- req_payload  in  32  payload; for CMD_AMP only [15:0] is sent
- req_valid  in  1  request present
- req_ready  out  1  builder can accept a request
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART transmitter accepts the byte this cycle
- frame_done  out  1  one-cycle pulse when the footer byte is accepted
- cmd_err  out  1  one-cycle pulse when a request with an unsupported cmd is accepted

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (reset=0 resets).
- Reset values: req_ready=0 while reset is asserted, and 1 in the first cycle after release (state IDLE). tx_valid=0, tx_data=0, frame_done=0, cmd_err=0, byte counter=0.
- Request handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. On accept, req_cmd and req_payload are latched; later changes on the inputs are ignored.
- Byte handshake: a byte transfers when tx_valid && tx_ready. While tx_valid=1, tx_data is held stable until accepted. tx_valid never drops without a transfer, except on reset.
- States:
  - IDLE: req_ready=1, tx_valid=0. Accept with a supported cmd -> HEADER. Accept with an unsupported cmd -> cmd_err pulses next cycle and the state stays IDLE; no bytes are emitted.
  - HEADER: tx_data=HEADER. On transfer -> CMD.
  - CMD: tx_data=latched cmd. On transfer -> DATA with byte counter=0.
  - DATA: tx_data is the payload byte selected by the counter, MSB first.
    - 4-byte cmds send [31:24], [23:16], [15:8], [7:0].
    - CMD_AMP sends [15:8], [7:0].
    - Counter increments per transfer. On transfer of the last byte (counter=3, or counter=1 for CMD_AMP) -> FOOTER.
  - FOOTER: tx_data=FOOTER. On transfer: frame_done pulses for one cycle and the state goes to IDLE.
- Latency:
  - Request accepted in cycle N -> tx_valid=1 with 0xAA in cycle N+1.
  - With tx_ready held at 1, one byte transfers per cycle: 7 bytes for FREQ/PHASE, 5 for AMP.
  - frame_done is asserted in the cycle after the footer transfer; req_ready=1 in that same cycle.
- Back-to-back frames: the minimum gap is one IDLE cycle between the footer transfer and the next header.
- Backpressure: tx_ready may stay low for any number of cycles in any state. Output is held, and the counter and state do not advance.
- Reset mid-frame: tx_valid drops immediately (asynchronous) and the partial frame is abandoned. The host parser recovers by header resync.
- No internal queue: a request arriving while busy waits, with req_ready=0.

Decomposition:
- Shared package packet_pkg holds:
  - HEADER/FOOTER and CMD_* constants;
  - a payload_len(cmd) function returning 4, 4, 2, or 0 for invalid;
  - the state encoding.
- packet_parser uses the same package, so both ends agree on the protocol.
- No sub-module: this is a single FSM plus a byte mux of roughly 150 lines.

Test Plan:
- FREQ frame: req cmd=01, payload=0x00068DB8, tx_ready=1 -> bytes AA 01 00 06 8D B8 55 on 7 consecutive cycles starting N+1; frame_done pulses once.
- AMP frame with stalls: cmd=03, payload=0x1234ABCD, tx_ready toggling 1/0 -> bytes AA 03 AB CD 55 only. tx_data is stable during stalls and no byte is duplicated.
- Invalid cmd 0x07: request accepted -> cmd_err pulse, tx_valid stays 0, and req_ready returns to 1 the next cycle.
- Back-to-back: PHASE 0x80000000, then FREQ 0x00000001 held valid -> AA 02 80 00 00 00 55, one gap cycle, then AA 01 00 00 00 01 55.
- Reset mid-frame: assert reset after 3 transfers -> tx_valid=0 asynchronously. After release, a new request produces a complete frame starting with AA.
- Loopback: builder output fed to packet_parser -> the parser's freq_reg/phase_reg equal the sent payloads.

Source files
------------

// File: rtl/packet_pkg.sv
// packet_pkg
//   Protocol definitions shared by both ends of the UART command link:
//   - frame delimiters and command codes
//   - payload_len(), which gives the payload size of a command (0 = unsupported)
//   - the state encoding of the frame builder FSM
package packet_pkg;

    localparam logic [7:0] HEADER    = 8'hAA;
    localparam logic [7:0] FOOTER    = 8'h55;
    localparam logic [7:0] CMD_FREQ  = 8'h01;
    localparam logic [7:0] CMD_PHASE = 8'h02;
    localparam logic [7:0] CMD_AMP   = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CMD,
        ST_DATA,
        ST_FOOTER
    } state_t;

    // Number of payload bytes carried by a command; 0 marks an unsupported code.
    function automatic logic [2:0] payload_len(input logic [7:0] cmd);
        case (cmd)
            CMD_FREQ,
            CMD_PHASE: return 3'd4;
            CMD_AMP:   return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/packet_builder.sv
// packet_builder
//   Serialises one command frame per accepted request into a byte stream for
//   the UART transmitter: HEADER, command byte, big-endian payload, FOOTER.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   req_cmd      command byte of the requested frame
//   req_payload  payload; for CMD_AMP only [15:0] is sent
//   req_valid    request present
//   req_ready    builder can accept a request (IDLE only)
//   tx_data      byte to the UART transmitter
//   tx_valid     tx_data is valid
//   tx_ready     transmitter accepts the byte this cycle
//   frame_done   one-cycle pulse after the footer byte is accepted
//   cmd_err      one-cycle pulse after a request with an unsupported cmd is accepted
module packet_builder
    import packet_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_payload,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done,
    output logic        cmd_err
);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_cnt;
    logic [1:0]  w_nextCnt;
    logic [7:0]  r_cmd;
    logic [31:0] r_payload;
    logic        r_frameDone;
    logic        r_cmdErr;

    logic        w_accept;
    logic [2:0]  w_reqLen;
    logic [2:0]  w_latLen;
    logic        w_lastByte;
    logic [1:0]  w_byteIdx;
    logic [7:0]  w_dataByte;

    // req_ready is gated by reset so it reads 0 for the whole time reset is held.
    assign req_ready  = reset && (r_state == ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_reqLen   = payload_len(req_cmd);
    assign w_latLen   = payload_len(r_cmd);
    assign w_lastByte = ({1'b0, r_cnt} == (w_latLen - 3'd1));

    // AMP frames carry only the low half-word, so their counter is offset by two
    // to start at [15:8]; wider commands start at [31:24].
    assign w_byteIdx  = (r_cmd == CMD_AMP) ? (r_cnt + 2'd2) : r_cnt;

    always_comb begin
        w_dataByte = 8'h00;
        case (w_byteIdx)
            2'd0:    w_dataByte = r_payload[31:24];
            2'd1:    w_dataByte = r_payload[23:16];
            2'd2:    w_dataByte = r_payload[15:8];
            default: w_dataByte = r_payload[7:0];
        endcase
    end

    assign frame_done = r_frameDone;
    assign cmd_err    = r_cmdErr;

    // Next-state and output decode. State and counter only move on a transfer,
    // which is what keeps tx_data stable while the transmitter stalls.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_reqLen != 3'd0)) begin
                    w_nextState = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    w_nextState = ST_CMD;
                end
            end
            ST_CMD: begin
                tx_valid = 1'b1;
                tx_data  = r_cmd;
                if (tx_ready) begin
                    w_nextState = ST_DATA;
                    w_nextCnt   = 2'd0;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = w_dataByte;
                if (tx_ready) begin
                    if (w_lastByte) begin
                        w_nextState = ST_FOOTER;
                    end else begin
                        w_nextCnt = r_cnt + 2'd1;
                    end
                end
            end
            ST_FOOTER: begin
                tx_valid = 1'b1;
                tx_data  = FOOTER;
                if (tx_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register, request latch and the two status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_cmd       <= 8'h00;
            r_payload   <= 32'h0;
            r_frameDone <= 1'b0;
            r_cmdErr    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_frameDone <= (r_state == ST_FOOTER) && tx_ready;
            r_cmdErr    <= w_accept && (w_reqLen == 3'd0);
            if (w_accept && (w_reqLen != 3'd0)) begin
                r_cmd     <= req_cmd;
                r_payload <= req_payload;
            end
        end
    end

endmodule
